// File: rtl/alu_bist_if.sv
// alu_bist_if: stimulus/result bus between the ALU self-test controller and its environment
interface alu_bist_if #(
  parameter int OP_W   = 4,
  parameter int CTRL_W = 3,
  parameter int OUT_W  = 8,
  parameter int ERR_W  = 16
);
  logic                     i_start;
  logic [OP_W-1:0]          o_op1;
  logic [OP_W-1:0]          o_op2;
  logic [CTRL_W-1:0]        o_ctrl;
  logic [OUT_W-1:0]         i_dat_a;
  logic [OUT_W-1:0]         i_dat_b;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_pass;
  logic [ERR_W-1:0]         o_err_cnt;
  logic [CTRL_W+2*OP_W-1:0] o_first_err;
  modport master (
    input  i_start, i_dat_a, i_dat_b,
    output o_op1, o_op2, o_ctrl, o_busy, o_done, o_pass, o_err_cnt, o_first_err
  );
  modport slave (
    output i_start, i_dat_a, i_dat_b,
    input  o_op1, o_op2, o_ctrl, o_busy, o_done, o_pass, o_err_cnt, o_first_err
  );
endinterface

// File: rtl/alu_bist.sv
// alu_bist: sweeps all {ctrl,op2,op1} vectors into two ALUs and compares them; ALU_BIST_STOP_ON_ERR_EN ends the run at the first mismatch
module alu_bist #(
  parameter int OP_W    = 4,
  parameter int CTRL_W  = 3,
  parameter int OUT_W   = 8,
  parameter int NUM_OPS = 5,
  parameter int ERR_W   = 16
) (
  input logic       i_clk,
  input logic       i_rst,
  alu_bist_if.master bus
);
  localparam int VW = CTRL_W + 2*OP_W;
  // op1 is innermost and ctrl outermost, so the concatenated vector simply counts up
  localparam logic [VW-1:0] LAST = {CTRL_W'(NUM_OPS-1), {2*OP_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [VW-1:0]    vec_q, first_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, done_q, pass_q;
  logic [OUT_W-1:0] diff;
  logic             mis, fin;
  always_comb begin
    diff  = bus.i_dat_a ^ bus.i_dat_b;
    mis   = |diff;
    err_d = (mis && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
`ifdef ALU_BIST_STOP_ON_ERR_EN
    fin   = (vec_q == LAST) || mis;
`else
    fin   = (vec_q == LAST);
`endif
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      first_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (state_q == RUN) begin
      err_q <= err_d;
      // a zero count means no mismatch yet this run, since the counter saturates instead of wrapping
      if (mis && err_q == '0) first_q <= vec_q;
      vec_q <= fin ? '0 : vec_q + VW'(1);
      if (fin) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= (err_d == '0);
      end
    end else if (bus.i_start) begin
      state_q <= RUN;
      vec_q   <= '0;
      first_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end
  end
  assign bus.o_op1       = vec_q[OP_W-1:0];
  assign bus.o_op2       = vec_q[2*OP_W-1:OP_W];
  assign bus.o_ctrl      = vec_q[VW-1:2*OP_W];
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_pass      = pass_q;
  assign bus.o_err_cnt   = err_q;
  assign bus.o_first_err = first_q;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed checks of the ALU self-test controller against hand-computed results
module tb_alu_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  int   total = 0;
  int   fails = 0;
  int   n;
  always #5 clk = ~clk;
  alu_bist_if #(.ERR_W(16)) b1 ();
  alu_bist_if #(.ERR_W(8))  b2 ();
  alu_bist #(.ERR_W(16)) dut (.i_clk(clk), .i_rst(rst), .bus(b1));
  alu_bist #(.ERR_W(8))  dut_sat (.i_clk(clk), .i_rst(rst), .bus(b2));
  function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
    return {b, a} ^ {c, 5'd0};
  endfunction
  assign b1.i_start = start;
  assign b2.i_start = start;
  assign b1.i_dat_a = alu(b1.o_op1, b1.o_op2, b1.o_ctrl);
  assign b1.i_dat_b = b1.i_dat_a
    ^ ((mode == 1 && b1.o_ctrl == 3'd2) ? 8'h01 : 8'h00)
    ^ ((mode == 2 && {b1.o_ctrl, b1.o_op2, b1.o_op1} == 11'h4FF) ? 8'h80 : 8'h00);
  assign b2.i_dat_a = alu(b2.o_op1, b2.o_op2, b2.o_ctrl);
  assign b2.i_dat_b = ~b2.i_dat_a;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, " op1"}, 32'(b1.o_op1), 0);
    check({tag, " op2"}, 32'(b1.o_op2), 0);
    check({tag, " ctrl"}, 32'(b1.o_ctrl), 0);
    check({tag, " busy"}, 32'(b1.o_busy), 0);
    check({tag, " done"}, 32'(b1.o_done), 0);
    check({tag, " pass"}, 32'(b1.o_pass), 0);
    check({tag, " err"}, 32'(b1.o_err_cnt), 0);
    check({tag, " first"}, 32'(b1.o_first_err), 0);
    check({tag, " sat err"}, 32'(b2.o_err_cnt), 0);
  endtask
  task automatic run(input int pulse_at, input int rst_at, output int cnt);
    cnt = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy after start", 32'(b1.o_busy), 1);
    while (!b1.o_done && cnt < 2000) begin
      if (mode == 2 && cnt < 18)
        check("vector", 32'({b1.o_ctrl, b1.o_op2, b1.o_op1}), 32'(cnt));
      if (cnt == pulse_at) start = 1'b1;
      if (cnt == rst_at) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cnt++;
      if (rst) begin
        check_zero("mid-run reset");
        rst = 1'b0;
        return;
      end
    end
  endtask
  task automatic check_done(input string tag, input int exp_n, input int exp_err, input int exp_first);
    check({tag, " cycles"}, 32'(n), 32'(exp_n));
    check({tag, " done"}, 32'(b1.o_done), 1);
    check({tag, " busy"}, 32'(b1.o_busy), 0);
    check({tag, " pass"}, 32'(b1.o_pass), 32'(exp_err == 0));
    check({tag, " err"}, 32'(b1.o_err_cnt), 32'(exp_err));
    check({tag, " first"}, 32'(b1.o_first_err), 32'(exp_first));
    check({tag, " vec"}, 32'({b1.o_ctrl, b1.o_op2, b1.o_op1}), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");
`ifdef ALU_BIST_STOP_ON_ERR_EN
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("stop done", 32'(b2.o_done), 1);
    check("stop err", 32'(b2.o_err_cnt), 1);
    check("stop first", 32'(b2.o_first_err), 0);
    check("stop pass", 32'(b2.o_pass), 0);
    check("stop vec", 32'({b2.o_ctrl, b2.o_op2, b2.o_op1}), 0);
    repeat (1300) @(posedge clk);
    #1;
    mode = 0;
    run(-1, -1, n);
    check_done("stop clean", 1280, 0, 0);
    mode = 1;
    run(-1, -1, n);
    check_done("stop ctrl2", 513, 1, 'h200);
    mode = 2;
    run(-1, -1, n);
    check_done("stop last", 1280, 1, 'h4FF);
`else
    mode = 0;
    run(-1, -1, n);
    check_done("clean", 1280, 0, 0);
    check("sat err", 32'(b2.o_err_cnt), 255);
    check("sat first", 32'(b2.o_first_err), 0);
    check("sat pass", 32'(b2.o_pass), 0);
    mode = 1;
    run(-1, -1, n);
    check_done("ctrl2 fault", 1280, 256, 'h200);
    mode = 2;
    run(-1, -1, n);
    check_done("last fault", 1280, 1, 'h4FF);
    mode = 0;
    run(-1, -1, n);
    check_done("restart from done", 1280, 0, 0);
    run(-1, 500, n);
    check("reset point", 32'(n), 501);
    run(-1, -1, n);
    check_done("after reset", 1280, 0, 0);
    run(300, -1, n);
    check_done("start ignored", 1280, 0, 0);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
